// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch
//  Purpose  : Fetch stage: issues one-word reads at the PC, captures the
//             returned instruction and hands it to decode over valid/ready.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              pc_enable,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_valid,
    output logic [DATA_W-1:0] ir_out,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [CNT_W-1:0]  fetch_count
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr_q;
    logic [DATA_W-1:0] r_ir;
    logic [ADDR_W-1:0] r_ir_pc;
    logic              r_ir_valid;
    logic [CNT_W-1:0]  r_fetch_count;

    logic w_req;
    logic w_capture;
    logic w_accept;

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_capture   = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_REQ: begin
                if (!flush) begin
                    w_req       = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_valid) begin
                    if (!flush) begin
                        w_capture   = 1'b1;
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_state_nxt = S_REQ;
                    end
                end else if (flush) begin
                    w_state_nxt = S_DROP;
                end
            end
            S_HOLD: begin
                // A flush in the same cycle as acceptance cancels the transfer
                if (flush) begin
                    w_state_nxt = S_REQ;
                end else if (ir_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_DROP: begin
                if (mem_valid) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_REQ;
            r_addr_q      <= '0;
            r_ir          <= '0;
            r_ir_pc       <= '0;
            r_ir_valid    <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ir_valid <= (w_state_nxt == S_HOLD);
            if (w_req) begin
                r_addr_q <= pc_in;
            end
            if (w_capture) begin
                r_ir    <= mem_rdata;
                r_ir_pc <= r_addr_q;
            end
            if (w_accept) begin
                r_fetch_count <= r_fetch_count + c_cnt_one;
            end
        end
    end

    // Strobes are gated by rst so nothing escapes while the state is undefined
    assign mem_req     = w_req & ~rst;
    assign pc_enable   = w_capture & ~rst;
    assign mem_addr    = (r_state == S_REQ) ? pc_in : r_addr_q;
    assign ir_out      = r_ir;
    assign ir_pc       = r_ir_pc;
    assign ir_valid    = r_ir_valid;
    assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire
